seq_detect_prog: RTL

SEQ_DETECT_PROG -- requirements
Module: seq_detect_prog

---
 rtl/seq_pkg.sv | 6 +
 rtl/seq_sat_cnt.sv | 24 ++
 rtl/seq_detect_prog.sv | 82 ++++++++
 3 files changed

// File: rtl/seq_pkg.sv
// Shared defaults for the programmable serial sequence detector.
package seq_pkg;
  localparam int         SEQ_PAT_W_DEF   = 4;
  localparam logic [3:0] SEQ_PAT_RST_DEF = 4'b1010;
  localparam int         SEQ_CNT_W_DEF   = 8;
endpackage

// File: rtl/seq_sat_cnt.sv
// Saturating up-counter: increments on inc, sticks at all-ones, async active-low clear.
module seq_sat_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         inc,
  output logic [W-1:0] q
);
  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != {W{1'b1}})) cnt_d = cnt_q + W'(1);
  end

  assign q = cnt_q;
endmodule

// File: rtl/seq_detect_prog.sv
// Programmable serial pattern detector with overlap control and registered match pulse.
// Match counter is built only when SEQ_DETECT_PROG_CNT_EN is defined; otherwise match_cnt is 0.
module seq_detect_prog
  import seq_pkg::*;
#(
  parameter int               PAT_W   = SEQ_PAT_W_DEF,
  parameter logic [PAT_W-1:0] PAT_RST = SEQ_PAT_RST_DEF,
  parameter int               CNT_W   = SEQ_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             en,
  input  logic             d,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat,
  input  logic             overlap,
  output logic             y,
  output logic [CNT_W-1:0] match_cnt
);
  localparam int                FILL_W   = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W);
  localparam logic [FILL_W-1:0] FILL_THR = FILL_W'(PAT_W - 1);

  logic [PAT_W-1:0]  hist_q, hist_d;
  logic [PAT_W-1:0]  pat_q, pat_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              y_q, y_d;

  logic              shift;
  logic [PAT_W-1:0]  hist_shift;
  logic              match;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      hist_q <= '0;
      pat_q  <= PAT_RST;
      fill_q <= '0;
      y_q    <= 1'b0;
    end else begin
      hist_q <= hist_d;
      pat_q  <= pat_d;
      fill_q <= fill_d;
      y_q    <= y_d;
    end
  end

  // A load outranks a shift, so the d bit on a load edge never enters history.
  assign shift      = en && !pat_load;
  assign hist_shift = {hist_q[PAT_W-2:0], d};
  // fill_q >= PAT_W-1 is the same test as (fill + 1) >= PAT_W without widening.
  assign match      = shift && (fill_q >= FILL_THR) && (hist_shift == pat_q);

  always_comb begin
    hist_d = hist_q;
    pat_d  = pat_q;
    fill_d = fill_q;
    y_d    = 1'b0;
    if (pat_load) begin
      pat_d  = pat;
      hist_d = '0;
      fill_d = '0;
    end else if (shift) begin
      hist_d = hist_shift;
      y_d    = match;
      if (match && !overlap)     fill_d = '0;
      else if (fill_q != FILL_MAX) fill_d = fill_q + FILL_W'(1);
    end
  end

  assign y = y_q;

`ifdef SEQ_DETECT_PROG_CNT_EN
  seq_sat_cnt #(.W(CNT_W)) u_cnt (
    .clk   (clk),
    .clr_n (clr_n),
    .inc   (match),
    .q     (match_cnt)
  );
`else
  assign match_cnt = '0;
`endif
endmodule
